// File: rtl/muldiv_unit_pkg.sv
// Shared types for the iterative multiply/divide unit: operation encoding and FSM states.
package muldiv_unit_pkg;

  typedef enum logic [1:0] {
    MD_MULTU = 2'd0,
    MD_MULT  = 2'd1,
    MD_DIVU  = 2'd2,
    MD_DIV   = 2'd3
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit_step.sv
// One CALC cycle of the datapath: STEP shift-add (mul) or restoring (div) iterations on
// unsigned magnitudes held in {hi, lo}; opnd is the multiplicand or divisor.
module muldiv_unit_step #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt
);

  logic [WIDTH-1:0] h;
  logic [WIDTH-1:0] l;
  logic [WIDTH:0]   t;

  always_comb begin
    h = hi;
    l = lo;
    t = '0;
    for (int i = 0; i < STEP; i++) begin
      if (is_div) begin
        // Shift the next dividend bit into the partial remainder; quotient bit fills lo[0].
        t = {h, l[WIDTH-1]};
        l = {l[WIDTH-2:0], 1'b0};
        if (t >= {1'b0, opnd}) begin
          t    = t - {1'b0, opnd};
          l[0] = 1'b1;
        end
        h = t[WIDTH-1:0];
      end else begin
        // lo holds the unconsumed multiplier bits; product bits shift in from the top.
        t = {1'b0, h} + (l[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        l = {t[0], l[WIDTH-1:1]};
        h = t[WIDTH:1];
      end
    end
    hi_nxt = h;
    lo_nxt = l;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit producing {hi,lo}; FSM IDLE -> CALC -> DONE with
// divide-by-zero early-out, flush abort and signed fixup on the final CALC cycle.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  muldiv_op_t       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_hi,
  output logic [WIDTH-1:0] resp_lo,
  output logic             busy,
  output muldiv_state_t    dbg_state
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never waits on ready, and the resp payload stays stable while resp_valid is high.

  muldiv_state_t    state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi_q, lo_q, opnd_q;
  logic             is_div_q, neg_q_q, neg_r_q;
  logic [WIDTH-1:0] step_hi, step_lo, fix_hi, fix_lo;
  logic [2*WIDTH-1:0] prod;
  logic             accept, a_neg, b_neg, div0;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign accept = req_valid & req_ready;
  assign a_neg  = req_op[0] & req_a[WIDTH-1];
  assign b_neg  = req_op[0] & req_b[WIDTH-1];
  assign a_mag  = a_neg ? -req_a : req_a;
  assign b_mag  = b_neg ? -req_b : req_b;
  assign div0   = req_op[1] & (req_b == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (flush)       state_nxt = IDLE;
            else if (accept) state_nxt = div0 ? DONE : CALC;
      CALC: if (flush)             state_nxt = IDLE;
            else if (cnt == LAST)  state_nxt = DONE;
      DONE: if (flush)             state_nxt = IDLE;
            else if (accept)       state_nxt = div0 ? DONE : CALC;
            else if (resp_ready)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = ~flush & ((state == IDLE) | ((state == DONE) & resp_ready));
    resp_valid = (state == DONE);
    busy       = (state != IDLE);
    resp_hi    = (state == DONE) ? hi_q : '0;
    resp_lo    = (state == DONE) ? lo_q : '0;
    dbg_state  = state;
  end

  muldiv_unit_step #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
    .is_div (is_div_q),
    .hi     (hi_q),
    .lo     (lo_q),
    .opnd   (opnd_q),
    .hi_nxt (step_hi),
    .lo_nxt (step_lo)
  );

  // Quotient sign follows a^b, remainder follows the dividend; products negate as a whole.
  assign prod = {step_hi, step_lo};
  always_comb begin
    if (is_div_q) begin
      fix_lo = neg_q_q ? -step_lo : step_lo;
      fix_hi = neg_r_q ? -step_hi : step_hi;
    end else begin
      {fix_hi, fix_lo} = neg_q_q ? -prod : prod;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
    end else if (accept) begin
      cnt      <= '0;
      is_div_q <= req_op[1];
      neg_q_q  <= a_neg ^ b_neg;
      neg_r_q  <= a_neg;
      if (div0) begin
        hi_q <= req_a;
        lo_q <= '1;
      end else if (req_op[1]) begin
        hi_q   <= '0;
        lo_q   <= a_mag;
        opnd_q <= b_mag;
      end else begin
        hi_q   <= '0;
        lo_q   <= b_mag;
        opnd_q <= a_mag;
      end
    end else if (flush) begin
      cnt <= '0;
    end else if (state == CALC) begin
      if (cnt == LAST) begin
        cnt  <= '0;
        hi_q <= fix_hi;
        lo_q <= fix_lo;
      end else begin
        cnt  <= cnt + 1'b1;
        hi_q <= step_hi;
        lo_q <= step_lo;
      end
    end
  end

endmodule
